// File: rtl/shift_fifo.sv
// Shift-register FIFO with DEPTH stages; the head is stage 0.
// Ports: clk/res/flush, push+data_in, pop/data_out, status flags, sticky errors.
module shift_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] fill_q, fill_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             pop_ok;
  logic             push_ok;
  logic [CW-1:0]    wr_idx;

  assign pop_ok  = pop && fill_q[0];
  assign push_ok = push && (!fill_q[DEPTH-1] || pop_ok);
  // first empty stage once this cycle's shift is applied
  assign wr_idx  = pop_ok ? cnt_q - CW'(1) : cnt_q;

  always_comb begin
    data_d = data_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = '0;
      end
      fill_d = '0;
      cnt_d  = '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          data_d[i] = data_q[i+1];
        end
        data_d[DEPTH-1] = '0;
        fill_d = {1'b0, fill_q[DEPTH-1:1]};
      end
      if (push_ok) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr_idx) begin
            data_d[i] = data_in;
            fill_d[i] = 1'b1;
          end
        end
      end
      if (push_ok && !pop_ok) begin
        cnt_d = cnt_q + CW'(1);
      end else if (pop_ok && !push_ok) begin
        cnt_d = cnt_q - CW'(1);
      end
      if (err_clr) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      // a new error beats a clear in the same cycle
      if (push && !push_ok) ovf_d = 1'b1;
      if (pop && !pop_ok)   unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      fill_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign data_out     = data_q[0];
  assign empty        = !fill_q[0];
  assign full         = fill_q[DEPTH-1];
  assign count        = cnt_q;
  assign almost_full  = (cnt_q >= CW'(AF_LEVEL));
  assign almost_empty = (cnt_q <= CW'(AE_LEVEL));
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_shift_fifo.sv
// Bench for shift_fifo: directed vector table, full-stream sequence,
// and a long randomized run against a queue model.
module tb_shift_fifo;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          res, flush, push, pop, err_clr;
  logic [W-1:0]  data_in, data_out;
  logic          empty, full, almost_full, almost_empty;
  logic          overflow, underflow;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .res(res), .flush(flush), .push(push),
    .data_in(data_in), .pop(pop), .data_out(data_out),
    .empty(empty), .full(full), .count(count),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  typedef struct {
    logic         push, pop, flush, clr;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    int           cnt;
    logic         ovf, unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic p, input logic q, input logic f,
                     input logic c, input logic [W-1:0] din,
                     input logic [W-1:0] dout, input int cnt,
                     input logic ovf, input logic unf);
    vec_t v;
    v.push = p; v.pop = q; v.flush = f; v.clr = c; v.din = din;
    v.dout = dout; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [W-1:0] dout,
                       input int cnt, input logic ovf, input logic unf);
    logic [W+CW+5:0] got, exp;
    got = {data_out, count, empty, full, almost_empty, almost_full,
           overflow, underflow};
    exp = {dout, CW'(cnt), cnt == 0, cnt == D, cnt <= 1, cnt >= D - 1,
           ovf, unf};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got dout=%h cnt=%0d e/f/ae/af=%b%b%b%b o/u=%b%b, want dout=%h cnt=%0d o/u=%b%b",
               nm, data_out, count, empty, full, almost_empty,
               almost_full, overflow, underflow, dout, cnt, ovf, unf);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic f,
                      input logic c, input logic r, input logic [W-1:0] din);
    push = p; pop = q; flush = f; err_clr = c; res = r; data_in = din;
    @(posedge clk);
    #1;
    push = 0; pop = 0; flush = 0; err_clr = 0; res = 0;
  endtask

  logic [W-1:0] mq[$];
  logic         m_ovf, m_unf;

  initial begin
    push = 0; pop = 0; flush = 0; err_clr = 0; res = 1; data_in = '0;
    // push 11/22/33 then drain
    add(1,0,0,0,'h11, 'h11,1,0,0);
    add(1,0,0,0,'h22, 'h11,2,0,0);
    add(1,0,0,0,'h33, 'h11,3,0,0);
    add(0,1,0,0,'0,   'h22,2,0,0);
    add(0,1,0,0,'0,   'h33,1,0,0);
    add(0,1,0,0,'0,   'h00,0,0,0);
    // fill with 1..8, overflow, drain
    for (int i = 1; i <= D; i++) add(1,0,0,0,W'(i), 1,i,0,0);
    add(1,0,0,0,'h99, 1,D,1,0);
    for (int i = 2; i <= D; i++) add(0,1,0,0,'0, W'(i),D+1-i,1,0);
    add(0,1,0,0,'0, 0,0,1,0);
    add(0,1,0,0,'0, 0,0,1,1);
    add(0,0,0,1,'0, 0,0,0,0);
    // push+pop on empty: push lands, underflow flags
    add(1,1,0,0,'h5, 'h5,1,0,1);
    add(1,0,0,0,'h6, 'h5,2,0,1);
    add(1,0,0,0,'h7, 'h5,3,0,1);
    add(1,0,0,0,'h8, 'h5,4,0,1);
    add(1,0,0,0,'h9, 'h5,5,0,1);
    // flush with push/pop: cleared, flags kept
    add(1,1,1,0,'h77, 0,0,0,1);
    add(0,1,1,0,'0,   0,0,0,1);
    // clear and new error same cycle: error wins
    add(0,1,0,1,'0,   0,0,0,1);
    add(0,0,0,1,'0,   0,0,0,0);

    repeat (2) @(posedge clk);
    #1;
    res = 0;
    check("reset", 0, 0, 0, 0);

    foreach (vecs[k]) begin
      step(vecs[k].push, vecs[k].pop, vecs[k].flush, vecs[k].clr, 0,
           vecs[k].din);
      check($sformatf("vec%0d", k), vecs[k].dout, vecs[k].cnt,
            vecs[k].ovf, vecs[k].unf);
    end

    // full FIFO streamed with push+pop for D cycles
    for (int i = 1; i <= D; i++) step(1,0,0,0,0,W'(i));
    check("stream_fill", 1, D, 0, 0);
    for (int k = 0; k < D; k++) begin
      step(1,1,0,0,0,W'('hA0 + k));
      check($sformatf("stream%0d", k),
            (k < D - 1) ? W'(k + 2) : W'('hA0), D, 0, 0);
    end

    // mid-stream reset clears flags too
    step(1,0,0,0,0,'h1);
    check("ovf_before_res", 'hA0, D, 1, 0);
    step(1,1,0,0,1,'h3);
    check("res_midstream", 0, 0, 0, 0);

    // randomized run against a queue model
    mq = {}; m_ovf = 0; m_unf = 0;
    for (int n = 0; n < 10000; n++) begin
      logic p, q, f, c, r, pa, ua;
      logic [W-1:0] din;
      p = ($urandom_range(99) < 55);
      q = ($urandom_range(99) < 45);
      f = ($urandom_range(199) == 0);
      c = ($urandom_range(29) == 0);
      r = ($urandom_range(499) == 0);
      din = $urandom;
      if (r) begin
        mq = {}; m_ovf = 0; m_unf = 0;
      end else if (f) begin
        mq = {};
      end else begin
        pa = q && (mq.size() > 0);
        ua = p && (mq.size() < D || pa);
        if (pa) void'(mq.pop_front());
        if (ua) mq.push_back(din);
        if (c) begin m_ovf = 0; m_unf = 0; end
        if (p && !ua) m_ovf = 1;
        if (q && !pa) m_unf = 1;
      end
      step(p, q, f, c, r, din);
      check($sformatf("rand%0d", n),
            (mq.size() > 0) ? mq[0] : '0, mq.size(), m_ovf, m_unf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_fifo.md
# shift_fifo

Parametrised shift-register FIFO built from a chain of DEPTH data/filled stages. Writes land in the first empty stage; reads shift the whole chain one stage toward the output. Adds occupancy count, programmable almost-full/almost-empty flags, flush, and sticky overflow/underflow error flags. Sits between producer and consumer logic wherever a short, fixed-latency elastic buffer is needed.

## Interface
- WIDTH, 32, data width in bits (>=1)
- DEPTH, 8, number of stages (>=2)
- AF_LEVEL, DEPTH-1, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
- clk  in  1  clock, all state updates on rising edge
- res  in  1  synchronous, active-high reset
- flush  in  1  discard all contents
- push  in  1  write request
- data_in  in  WIDTH  write data
- pop  in  1  read request; consumes data_out
- data_out  out  WIDTH  stage 0 contents (head of queue)
- empty  out  1  no stage filled
- full  out  1  all stages filled
- count  out  $clog2(DEPTH+1)  number of filled stages
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- overflow  out  1  sticky: push rejected while full
- underflow  out  1  sticky: pop rejected while empty
- err_clr  in  1  clears overflow and underflow

## Operation
- Stage i holds data[i] and filled[i]; stage 0 is the head. Filled stages are always contiguous from stage 0 (filled[i+1] implies filled[i]).
- Priority per cycle: res > flush > push/pop.
- res: all data = 0, all filled = 0, count = 0, overflow = underflow = 0. Outputs after reset: data_out = 0, empty = 1, full = 0, count = 0, almost_full = 0 (unless AF_LEVEL = 0, illegal), almost_empty = 1.
- flush: as res but overflow/underflow keep their values; push/pop in the same cycle ignored, no error flags set.
- Accepted pop (pop && !empty): every stage i loads stage i+1 (data and filled); stage DEPTH-1 loads data 0, filled 0.
- Accepted push (push && (!full || pop_accepted)): data_in written to the stage that is the first empty one after any shift of this cycle; that stage's filled set.
- push && pop while full: both accepted; data_in lands in stage DEPTH-1; count unchanged.
- push && pop while empty: push accepted into stage 0; pop rejected, underflow set; count becomes 1.
- push while full, no pop: rejected, contents unchanged, overflow set.
- pop while empty: rejected, underflow set.
- err_clr clears both error flags; a new error in the same cycle wins (flag stays/gets set).
- Vacated stages always hold 0, so data_out = 0 whenever empty.
- count: +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither; never wraps.
- empty, full, almost_* are derived combinationally from registered state only; no combinational path from any input to any output.

## Timing
- Write-to-read latency: push in cycle n into an empty FIFO -> data_out valid, empty = 0 in cycle n+1.
- Pop in cycle n -> next entry on data_out in cycle n+1.
- Sustained push+pop every cycle at any occupancy 1..DEPTH: throughput 1 word/cycle, order preserved.
- Error flags assert the cycle after the offending request and hold until err_clr or res.
- res or flush asserted mid-stream: state cleared at that edge; requests in that cycle have no effect.

## Test plan
- Reset, then push 0x11,0x22,0x33 over 3 cycles -> count 1,2,3; data_out 0x11 from cycle after first push; almost_empty drops when count reaches 2.
- Fill DEPTH=8 with 1..8, push 0x99 -> full = 1, count 8, overflow = 1, contents unchanged; pops return 1..8 in order, then empty = 1, data_out = 0.
- Full FIFO, push 0xAA with pop every cycle for 8 cycles -> count stays 8, outputs 1..8, then 0xAA is at stage 7 after first cycle and reaches head after 8 pops.
- Empty FIFO, push 0x5 and pop same cycle -> count 1, data_out 0x5, underflow = 1; err_clr -> underflow 0.
- Fill to 5, assert flush with push -> count 0, empty 1, data_out 0, error flags unchanged.
- Random push/pop for 10k cycles vs. reference queue model -> data order, count, all flags match every cycle.
